// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared pipeline encodings and defaults for the hazard/stall controller.
package hazard_stall_ctrl_pkg;
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, TNEVER = 2'd3} tuse_e;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// md_busy_timer: multiply/divide busy window; a start reloads the latency, otherwise count down to zero.
module md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = start_i ? (div_i ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT))
              : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew and mult/div hazard detection driving F/D and D/E pipeline controls.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a_rs_D,
    input  logic [4:0]  a_rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  a_WB_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  a_WB_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        PC_EN,
    output logic        FD_EN,
    output logic        DE_EN,
    output logic        DE_clr,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    logic        stall_rs, stall_rt, stall_md;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start_E),
        .div_i   (md_div_E),
        .busy_o  (md_busy)
    );

    always_comb begin
        stall_rs = (a_rs_D != REG_ZERO) &&
                   ((a_rs_D == a_WB_E && tuse_rs_D < tnew_E) ||
                    (a_rs_D == a_WB_M && tuse_rs_D < tnew_M));
        stall_rt = (a_rt_D != REG_ZERO) &&
                   ((a_rt_D == a_WB_E && tuse_rt_D < tnew_E) ||
                    (a_rt_D == a_WB_M && tuse_rt_D < tnew_M));
        stall_md = md_use_D && (md_busy || md_start_E);
        // Held low during reset so the pipeline runs freely until released.
        stall    = ~reset & (stall_rs | stall_rt | stall_md);
        PC_EN    = ~stall;
        FD_EN    = ~stall;
        DE_EN    = 1'b1;
        DE_clr   = stall;
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
endmodule
